memory_arbiter_rv32: RTL and testbench

//  Shares the single-port RV32 memory between instruction fetch and load/store.

---
 rtl/memory_arbiter_rv32.sv | 151 +++++++++++++++
 tb/tb_memory_arbiter_rv32.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_rv32.sv
// memory_arbiter_rv32
//   Shares one single-port RV32 memory between instruction fetch and
//   load/store. One transaction is in flight at a time, sequenced by an
//   IDLE -> ISSUE -> WAIT -> ACK state machine. Data requests win ties.
//   A starvation counter forces fetch to win after MAX_STARVE consecutive
//   losses.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   enable                   0 blocks new grants; a transaction in flight completes
//   fetch_req/addr           fetch read request
//   fetch_ack/rdata          one-cycle ack pulse; rdata holds the last fetched word
//   data_req/we/wstrb/addr/wdata   load/store request
//   data_ack/rdata           one-cycle ack pulse; rdata holds the last load word
//   mem_en/we/wstrb/addr/wdata     memory request, mem_en high for exactly one cycle
//   mem_rdata                read data, valid MEM_LATENCY cycles after mem_en is sampled
//   busy                     1 whenever the FSM is not in IDLE
//   state_dbg                current FSM state (0=IDLE 1=ISSUE 2=WAIT 3=ACK)
//
// Handshake: a requester raises req with stable address/data and holds it
//   until its ack pulse. Request inputs are sampled only at the grant edge.
//   In the ack cycle the requester must drop req or present a new request
//   by the following cycle; holding req high means a new request.

module memory_arbiter_rv32 #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STARVE  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [3:0]            data_wstrb,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_ack,
  output logic [31:0]           data_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int SW = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            grant_data;  // 1 = data side owns the transaction in flight
  logic            grant_we;    // 1 = transaction in flight is a store
  logic            pick_fetch;

  // Fetch wins when alone, or when it has lost MAX_STARVE ties in a row.
  assign pick_fetch = fetch_req && (!data_req || (starve_cnt == SW'(MAX_STARVE)));

  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      grant_data  <= 1'b0;
      grant_we    <= 1'b0;
      fetch_ack   <= 1'b0;
      fetch_rdata <= '0;
      data_ack    <= 1'b0;
      data_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wstrb   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && (fetch_req || data_req)) begin
            state  <= S_ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (pick_fetch) begin
              grant_data <= 1'b0;
              grant_we   <= 1'b0;
              mem_we     <= 1'b0;
              mem_wstrb  <= 4'b0000;
              mem_addr   <= fetch_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              grant_data <= 1'b1;
              grant_we   <= data_we;
              mem_we     <= data_we;
              // Loads never present strobes to the memory.
              mem_wstrb  <= data_we ? data_wstrb : 4'b0000;
              mem_addr   <= data_addr;
              mem_wdata  <= data_wdata;
              // Only a contested data win counts as a fetch loss.
              if (fetch_req) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          mem_en   <= 1'b0;
          wait_cnt <= CW'(MEM_LATENCY);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == CW'(1)) begin
            state <= S_ACK;
            if (grant_data) begin
              data_ack <= 1'b1;
              if (!grant_we) data_rdata <= mem_rdata;
            end else begin
              fetch_ack   <= 1'b1;
              fetch_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACK: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter_rv32.sv
// Directed testbench for memory_arbiter_rv32. Instance dut uses MEM_LATENCY=1,
// instance dut3 uses MEM_LATENCY=3. Each has its own memory model that only
// presents valid read data in the exact cycle the latency dictates.

module tb_memory_arbiter_rv32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- dut (MEM_LATENCY=1) ----------------
  logic        enable;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  state_dbg;

  memory_arbiter_rv32 #(.ADDR_WIDTH(32), .MEM_LATENCY(1), .MAX_STARVE(3)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- dut3 (MEM_LATENCY=3) ----------------
  logic        l3_data_req;
  logic        l3_fetch_ack;
  logic [31:0] l3_fetch_rdata;
  logic        l3_data_ack;
  logic [31:0] l3_data_rdata;
  logic        l3_mem_en;
  logic        l3_mem_we;
  logic [3:0]  l3_mem_wstrb;
  logic [31:0] l3_mem_addr;
  logic [31:0] l3_mem_wdata;
  logic [31:0] l3_mem_rdata;
  logic        l3_busy;
  logic [1:0]  l3_state_dbg;

  memory_arbiter_rv32 #(.ADDR_WIDTH(32), .MEM_LATENCY(3), .MAX_STARVE(3)) dut3 (
    .clock(clock), .reset(reset), .enable(1'b1),
    .fetch_req(1'b0), .fetch_addr(32'h0),
    .fetch_ack(l3_fetch_ack), .fetch_rdata(l3_fetch_rdata),
    .data_req(l3_data_req), .data_we(1'b0), .data_wstrb(4'b0000),
    .data_addr(32'h0000_0080), .data_wdata(32'h0),
    .data_ack(l3_data_ack), .data_rdata(l3_data_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_wstrb(l3_mem_wstrb),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata),
    .busy(l3_busy), .state_dbg(l3_state_dbg)
  );

  // ---------------- memory models ----------------
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h0050_0093;  // byte address 0x10
    if (i == 32) return 32'hCAFE_F00D;  // byte address 0x80
    return 32'hA500_0000 | 32'(i);
  endfunction

  logic [31:0] mem_a [0:63];
  logic [31:0] rd_a;
  assign mem_rdata = rd_a;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
      rd_a <= BAD;
    end else if (mem_en) begin
      rd_a <= mem_a[mem_addr[7:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem_a[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      rd_a <= BAD;
    end
  end

  logic [31:0] d0, d1, d2;
  assign l3_mem_rdata = d2;
  always @(posedge clock) begin
    d0 <= l3_mem_en ? init_word(int'(l3_mem_addr[7:2])) : BAD;
    d1 <= d0;
    d2 <= d1;
  end

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 (requests already driven). Walks ISSUE, WAIT, ACK and
  // returns in the following IDLE cycle.
  task automatic txn_l1(input string tag, input logic is_data, input logic we,
                        input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] rd_exp);
    tick();  // cycle 1: ISSUE
    check1({tag, "_issue_en"}, mem_en, 1'b1);
    check32({tag, "_issue_addr"}, mem_addr, addr);
    check1({tag, "_issue_we"}, mem_we, we);
    check32({tag, "_issue_wstrb"}, {28'h0, mem_wstrb}, {28'h0, strb});
    if (we) check32({tag, "_issue_wdata"}, mem_wdata, wd);
    check1({tag, "_issue_busy"}, busy, 1'b1);
    tick();  // cycle 2: WAIT
    check1({tag, "_wait_en"}, mem_en, 1'b0);
    check1({tag, "_wait_fack"}, fetch_ack, 1'b0);
    check1({tag, "_wait_dack"}, data_ack, 1'b0);
    tick();  // cycle 3: ACK
    check1({tag, "_ack_fetch"}, fetch_ack, !is_data);
    check1({tag, "_ack_data"}, data_ack, is_data);
    if (is_data) check32({tag, "_data_rdata"}, data_rdata, rd_exp);
    else         check32({tag, "_fetch_rdata"}, fetch_rdata, rd_exp);
    tick();  // cycle 4: IDLE
    check1({tag, "_idle_fack"}, fetch_ack, 1'b0);
    check1({tag, "_idle_dack"}, data_ack, 1'b0);
    check1({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    enable      = 1'b1;
    fetch_req   = 1'b0;
    fetch_addr  = 32'h0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_wstrb  = 4'b0000;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    l3_data_req = 1'b0;

    // Reset state
    tick();
    tick();
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_fack", fetch_ack, 1'b0);
    check1("rst_dack", data_ack, 1'b0);
    check32("rst_fetch_rdata", fetch_rdata, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_state", {30'h0, state_dbg}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: fetch at 0x10
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0010;
    txn_l1("t1_fetch", 1'b0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0050_0093);
    fetch_req = 1'b0;
    tick();

    // 2: store 0xDEADBEEF, strobes 0011, at 0x40; data_rdata stays 0
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h0000_0040;
    data_wdata = 32'hDEAD_BEEF;
    txn_l1("t2_store", 1'b1, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF, 32'h0);
    // read back: only the low two bytes were written
    data_we    = 1'b0;
    data_wstrb = 4'b1111;
    txn_l1("t2_readback", 1'b1, 1'b0, 32'h40, 4'b0000, 32'h0, 32'hA500_BEEF);
    data_req = 1'b0;
    tick();

    // 3: both held, loads only -> D,D,D,F,D,D,D,F
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0020;
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_wstrb = 4'b1111;
    data_addr  = 32'h0000_0044;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3)
        txn_l1($sformatf("t3_g%0d_F", k), 1'b0, 1'b0, 32'h20, 4'b0000, 32'h0, 32'hA500_0008);
      else
        txn_l1($sformatf("t3_g%0d_D", k), 1'b1, 1'b0, 32'h44, 4'b0000, 32'h0, 32'hA500_0011);
    end

    // 4: enable=0 with both pending for 10 cycles
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check1($sformatf("t4_hold%0d_en", k), mem_en, 1'b0);
      check1($sformatf("t4_hold%0d_busy", k), busy, 1'b0);
    end
    enable    = 1'b1;
    data_addr = 32'h0000_0048;
    txn_l1("t4_release_D", 1'b1, 1'b0, 32'h48, 4'b0000, 32'h0, 32'hA500_0012);
    fetch_req = 1'b0;
    data_req  = 1'b0;
    tick();

    // 5: reset in WAIT
    data_req  = 1'b1;
    data_addr = 32'h0000_004C;
    tick();  // ISSUE
    check1("t5_issue_en", mem_en, 1'b1);
    tick();  // WAIT
    check32("t5_wait_state", {30'h0, state_dbg}, 32'h2);
    reset    = 1'b1;
    data_req = 1'b0;
    #1;
    check1("t5_rst_busy", busy, 1'b0);
    check1("t5_rst_en", mem_en, 1'b0);
    check32("t5_rst_data_rdata", data_rdata, 32'h0);
    check32("t5_rst_mem_addr", mem_addr, 32'h0);
    check32("t5_rst_state", {30'h0, state_dbg}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check1($sformatf("t5_noack%0d", k), data_ack, 1'b0);
    end
    data_req = 1'b1;
    txn_l1("t5_rerequest", 1'b1, 1'b0, 32'h4C, 4'b0000, 32'h0, 32'hA500_0013);
    data_req = 1'b0;
    tick();

    // 6: MEM_LATENCY=3 load at 0x80 -> ack in cycle 5
    l3_data_req = 1'b1;
    tick();
    check1("t6_issue_en", l3_mem_en, 1'b1);
    check32("t6_issue_addr", l3_mem_addr, 32'h80);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check1($sformatf("t6_c%0d_noack", k), l3_data_ack, 1'b0);
      check1($sformatf("t6_c%0d_busy", k), l3_busy, 1'b1);
    end
    tick();
    check1("t6_c5_ack", l3_data_ack, 1'b1);
    check32("t6_rdata", l3_data_rdata, 32'hCAFE_F00D);
    check1("t6_no_fetch_ack", l3_fetch_ack, 1'b0);
    l3_data_req = 1'b0;
    tick();
    check1("t6_ack_pulse", l3_data_ack, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
